// File: rtl/alu.sv
// Four-bank 32-bit registered ALU: each bank turns a command packet into a
// status/result packet one clock later. Banks share only clock and reset.
package alu_pkg;
  typedef enum logic [1:0] {
    NO_OP    = 2'd0,
    ADD      = 2'd1,
    SUBTRACT = 2'd2,
    AND      = 2'd3
  } command_names_t;

  typedef enum logic [1:0] {
    NO_RESPONSE = 2'd0,
    SUCCESS     = 2'd1,
    OVERFLOW    = 2'd2,
    UNDERFLOW   = 2'd3
  } response_names_t;

  typedef struct packed {
    command_names_t command;
    logic [31:0]    data1;
    logic [31:0]    data2;
  } input_packet_t;

  typedef struct packed {
    response_names_t response;
    logic [31:0]     data;
  } output_packet_t;
endpackage

module alu
  import alu_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  input_packet_t  [3:0] input_packet,
  output output_packet_t [3:0] output_packet
);

  output_packet_t [3:0] next_packet;
  logic [32:0]          sum [4];

  always_comb begin
    next_packet = output_packet;
    for (int unsigned i = 0; i < 4; i++) begin
      sum[i] = {1'b0, input_packet[i].data1} + {1'b0, input_packet[i].data2};
      case (input_packet[i].command)
        NO_OP: begin
          // Data deliberately keeps its last value; only the status clears.
          next_packet[i].response = NO_RESPONSE;
        end
        ADD: begin
          next_packet[i].data     = sum[i][31:0];
          next_packet[i].response = sum[i][32] ? OVERFLOW : SUCCESS;
        end
        SUBTRACT: begin
          next_packet[i].data     = input_packet[i].data1 - input_packet[i].data2;
          next_packet[i].response = (input_packet[i].data2 > input_packet[i].data1)
                                    ? UNDERFLOW : SUCCESS;
        end
        AND: begin
          next_packet[i].data     = input_packet[i].data1 & input_packet[i].data2;
          next_packet[i].response = SUCCESS;
        end
        default: next_packet[i].response = NO_RESPONSE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) output_packet <= '0;
    else        output_packet <= next_packet;
  end

endmodule

// File: tb/tb_alu.sv
// Directed bench for the four-bank ALU: hand-computed vectors, a randomized
// idle-gap phase against a small reference model, and async reset checks.
module tb_alu;
  import alu_pkg::*;

  logic                 clock;
  logic                 reset;
  input_packet_t  [3:0] input_packet;
  output_packet_t [3:0] output_packet;

  int checks   = 0;
  int failures = 0;

  alu dut (
    .clock        (clock),
    .reset        (reset),
    .input_packet (input_packet),
    .output_packet(output_packet)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic output_packet_t pk(input response_names_t r, input logic [31:0] d);
    output_packet_t p;
    p.response = r;
    p.data     = d;
    return p;
  endfunction

  // Reference behaviour written from the operation rules, not from the RTL.
  function automatic output_packet_t model(input command_names_t c, input logic [31:0] a,
                                           input logic [31:0] b, input output_packet_t prev);
    logic [32:0] wide;
    case (c)
      ADD: begin
        wide = {1'b0, a} + {1'b0, b};
        return pk(wide[32] ? OVERFLOW : SUCCESS, wide[31:0]);
      end
      SUBTRACT: return pk((a < b) ? UNDERFLOW : SUCCESS, a - b);
      AND:      return pk(SUCCESS, a & b);
      default:  return pk(NO_RESPONSE, prev.data);
    endcase
  endfunction

  task automatic check(input string tag, input output_packet_t obs, input output_packet_t exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed resp=%0d data=%h expected resp=%0d data=%h",
             tag, obs.response, obs.data, exp.response, exp.data);
    end
  endtask

  task automatic drive(input int b, input command_names_t c, input logic [31:0] a,
                       input logic [31:0] d);
    input_packet[b].command = c;
    input_packet[b].data1   = a;
    input_packet[b].data2   = d;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  output_packet_t exp_q [4];
  int             gap   [4];
  command_names_t rc;
  logic [31:0]    ra, rb;

  initial begin
    reset        = 1'b0;
    input_packet = '0;
    #1;
    for (int b = 0; b < 4; b++) check($sformatf("reset_b%0d", b), output_packet[b], pk(NO_RESPONSE, '0));
    @(negedge clock);
    reset = 1'b1;
    tick();
    check("post_release_idle", output_packet[0], pk(NO_RESPONSE, 32'h0));

    drive(0, ADD, 32'h0000_0005, 32'h0000_0003);
    tick();
    check("add_ok", output_packet[0], pk(SUCCESS, 32'h0000_0008));
    check("add_ok_b1_idle", output_packet[1], pk(NO_RESPONSE, 32'h0));

    drive(0, ADD, 32'hFFFF_FFFF, 32'h0000_0002);
    tick();
    check("add_overflow", output_packet[0], pk(OVERFLOW, 32'h0000_0001));

    drive(0, NO_OP, '0, '0);
    drive(1, SUBTRACT, 32'h0000_0003, 32'h0000_0005);
    tick();
    check("sub_underflow", output_packet[1], pk(UNDERFLOW, 32'hFFFF_FFFE));
    check("b0_noop_hold", output_packet[0], pk(NO_RESPONSE, 32'h0000_0001));

    drive(1, SUBTRACT, 32'h10, 32'h10);
    tick();
    check("sub_equal", output_packet[1], pk(SUCCESS, 32'h0));

    drive(1, NO_OP, '0, '0);
    drive(2, AND, 32'hF0F0_F0F0, 32'hFF00_FF00);
    tick();
    check("and", output_packet[2], pk(SUCCESS, 32'hF000_F000));
    tick();
    check("and_held", output_packet[2], pk(SUCCESS, 32'hF000_F000));
    drive(2, NO_OP, '0, '0);
    tick();
    check("and_then_noop", output_packet[2], pk(NO_RESPONSE, 32'hF000_F000));

    drive(0, SUBTRACT, 32'h0000_0001, 32'h0000_0002);
    drive(1, ADD, 32'h8000_0000, 32'h8000_0000);
    drive(2, NO_OP, 32'h1234_5678, 32'h1);
    drive(3, AND, 32'h1234_5678, 32'h0F0F_0F0F);
    tick();
    check("indep_b0", output_packet[0], pk(UNDERFLOW, 32'hFFFF_FFFF));
    check("indep_b1", output_packet[1], pk(OVERFLOW, 32'h0000_0000));
    check("indep_b2", output_packet[2], pk(NO_RESPONSE, 32'hF000_F000));
    check("indep_b3", output_packet[3], pk(SUCCESS, 32'h0204_0608));

    for (int b = 0; b < 4; b++) begin
      exp_q[b] = output_packet[b];
      gap[b]   = 0;
    end
    for (int cyc = 0; cyc < 500; cyc++) begin
      for (int b = 0; b < 4; b++) begin
        if (gap[b] == 0) begin
          rc = command_names_t'($urandom_range(1, 3));
          ra = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
          rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
          drive(b, rc, ra, rb);
          exp_q[b] = model(rc, ra, rb, exp_q[b]);
          gap[b]   = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 3);
        end else begin
          drive(b, NO_OP, $urandom, $urandom);
          exp_q[b] = model(NO_OP, '0, '0, exp_q[b]);
          gap[b]--;
        end
      end
      tick();
      for (int b = 0; b < 4; b++) check($sformatf("rand_c%0d_b%0d", cyc, b), output_packet[b], exp_q[b]);
    end

    for (int b = 0; b < 3; b++) drive(b, NO_OP, '0, '0);
    drive(3, ADD, 32'h0000_0007, 32'h0000_0009);
    tick();
    check("held_add", output_packet[3], pk(SUCCESS, 32'h0000_0010));
    #2 reset = 1'b0;
    #1;
    for (int b = 0; b < 4; b++) check($sformatf("async_rst_b%0d", b), output_packet[b], pk(NO_RESPONSE, '0));
    tick();
    check("rst_hold_edge", output_packet[3], pk(NO_RESPONSE, 32'h0));
    #2 reset = 1'b1;
    #1;
    check("release_no_edge", output_packet[3], pk(NO_RESPONSE, 32'h0));
    tick();
    check("release_first_edge", output_packet[3], pk(SUCCESS, 32'h0000_0010));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
